// File: rtl/pe_array_overlay.sv
// rtl/pe_array_overlay.sv - complex dot-product PE array with a 4-stage pipelined adder tree
// Loads NUM_PE complex coefficients, then emits one dot product per NUM_PE-sample frame.
module pe_array_overlay #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PE     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    din_overlay_v,
    input  logic [2*DATA_WIDTH-1:0] din_overlay,
    output logic                    dout_overlay_v,
    output logic [2*DATA_WIDTH-1:0] dout_overlay
);
    localparam int DW  = DATA_WIDTH;
    localparam int W   = 2 * DW;
    localparam int LVL = $clog2(NUM_PE);
    localparam int IW  = (NUM_PE > 1) ? LVL : 1;
    localparam int PW  = 2 * DW + 1;
    localparam int AW  = PW + LVL;
    // Tree levels folded into the third stage; the rest share the output stage.
    localparam int S3  = LVL - LVL / 2;
    localparam int GS  = 1 << S3;
    localparam int NG  = NUM_PE >> S3;
    localparam logic [IW-1:0] LAST = IW'(NUM_PE - 1);

    typedef enum logic {LOAD_COEF, RUN} state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            fire_q, v1_q, v2_q, v3_q;
    logic [W-1:0]    coef_q [NUM_PE];
    logic [W-1:0]    data_q [NUM_PE];
    logic [W-1:0]    opa_q  [NUM_PE];
    logic [W-1:0]    opb_q  [NUM_PE];
    logic signed [PW-1:0] pr_q [NUM_PE];
    logic signed [PW-1:0] pi_q [NUM_PE];
    logic signed [AW-1:0] sr_q [NG];
    logic signed [AW-1:0] si_q [NG];
    logic signed [PW-1:0] mul_r [NUM_PE];
    logic signed [PW-1:0] mul_i [NUM_PE];
    logic signed [AW-1:0] grp_r [NG];
    logic signed [AW-1:0] grp_i [NG];
    logic signed [AW-1:0] tot_r, tot_i;
    logic                 dout_v_q;
    logic [W-1:0]         dout_q;

    function automatic logic signed [PW-1:0] cmul_re(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [DW-1:0] ar, ai, br, bi;
        ar = a[W-1:DW]; ai = a[DW-1:0];
        br = b[W-1:DW]; bi = b[DW-1:0];
        return PW'(ar) * PW'(br) - PW'(ai) * PW'(bi);
    endfunction

    function automatic logic signed [PW-1:0] cmul_im(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [DW-1:0] ar, ai, br, bi;
        ar = a[W-1:DW]; ai = a[DW-1:0];
        br = b[W-1:DW]; bi = b[DW-1:0];
        return PW'(ar) * PW'(bi) + PW'(ai) * PW'(br);
    endfunction

    // Wrap-around narrowing: keep only the low DW bits of each component.
    function automatic logic [W-1:0] narrow(input logic signed [AW-1:0] re, input logic signed [AW-1:0] im);
        return {re[DW-1:0], im[DW-1:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LOAD_COEF;
            idx_q   <= '0;
            fire_q  <= 1'b0;
            for (int k = 0; k < NUM_PE; k++) begin
                coef_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else if (load) begin
            state_q <= LOAD_COEF;
            idx_q   <= '0;
            fire_q  <= 1'b0;
        end else begin
            fire_q <= 1'b0;
            if (din_overlay_v) begin
                if (state_q == LOAD_COEF) coef_q[idx_q] <= din_overlay;
                else                      data_q[idx_q] <= din_overlay;
                if (idx_q == LAST) begin
                    idx_q   <= '0;
                    state_q <= RUN;
                    fire_q  <= (state_q == RUN);
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        tot_r = '0;
        tot_i = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            mul_r[k] = cmul_re(opa_q[k], opb_q[k]);
            mul_i[k] = cmul_im(opa_q[k], opb_q[k]);
        end
        for (int g = 0; g < NG; g++) begin
            grp_r[g] = '0;
            grp_i[g] = '0;
            for (int j = 0; j < GS; j++) begin
                grp_r[g] = grp_r[g] + AW'(pr_q[g*GS+j]);
                grp_i[g] = grp_i[g] + AW'(pi_q[g*GS+j]);
            end
            tot_r = tot_r + sr_q[g];
            tot_i = tot_i + si_q[g];
        end
    end

    always_ff @(posedge clk) begin
        opa_q <= coef_q;
        opb_q <= data_q;
        for (int k = 0; k < NUM_PE; k++) begin
            pr_q[k] <= mul_r[k];
            pi_q[k] <= mul_i[k];
        end
        for (int g = 0; g < NG; g++) begin
            sr_q[g] <= grp_r[g];
            si_q[g] <= grp_i[g];
        end
    end

    // A load kills every in-flight valid but leaves the last result on dout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            dout_v_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            v1_q     <= fire_q & ~load;
            v2_q     <= v1_q & ~load;
            v3_q     <= v2_q & ~load;
            dout_v_q <= v3_q & ~load;
            if (v3_q && !load) dout_q <= narrow(tot_r, tot_i);
        end
    end

    assign dout_overlay_v = dout_v_q;
    assign dout_overlay   = dout_q;
endmodule

// File: tb/tb_pe_array_overlay.sv
// tb/tb_pe_array_overlay.sv - self-checking bench for pe_array_overlay
// Arithmetic reference model tracks coefficients, frames and expected output times.
module tb_pe_array_overlay;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        din_v = 1'b0;
    logic [31:0] din = '0;
    logic        dout_v;
    logic [31:0] dout;

    pe_array_overlay #(.DATA_WIDTH(16), .NUM_PE(8)) dut (
        .clk(clk), .rst(rst), .load(load),
        .din_overlay_v(din_v), .din_overlay(din),
        .dout_overlay_v(dout_v), .dout_overlay(dout)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0, cyc = 0;
    logic [31:0] m_coef [8];
    logic [31:0] m_dat  [8];
    int          m_cnt = 0;
    bit          m_loading = 1'b1;
    logic [31:0] exp_val [$];
    int          exp_cyc [$];
    logic [31:0] obs_val [$];
    int          obs_cyc [$];

    always @(negedge clk) begin
        if (dout_v === 1'b1) begin
            obs_val.push_back(dout);
            obs_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] dot();
        longint sr = 0, si = 0, ar, ai, br, bi;
        for (int k = 0; k < 8; k++) begin
            ar = longint'($signed(m_coef[k][31:16]));
            ai = longint'($signed(m_coef[k][15:0]));
            br = longint'($signed(m_dat[k][31:16]));
            bi = longint'($signed(m_dat[k][15:0]));
            sr += ar * br - ai * bi;
            si += ar * bi + ai * br;
        end
        return {sr[15:0], si[15:0]};
    endfunction

    task automatic drive(input bit v, input logic [31:0] w, input bit ld);
        din_v = v; din = w; load = ld;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            m_loading = 1'b1; m_cnt = 0;
            for (int k = 0; k < 8; k++) begin m_coef[k] = '0; m_dat[k] = '0; end
            exp_val.delete(); exp_cyc.delete();
        end else if (ld) begin
            m_loading = 1'b1; m_cnt = 0;
            while (exp_cyc.size() > 0 && exp_cyc[$] >= cyc) begin
                void'(exp_cyc.pop_back()); void'(exp_val.pop_back());
            end
        end else if (v) begin
            if (m_loading) m_coef[m_cnt] = w; else m_dat[m_cnt] = w;
            m_cnt++;
            if (m_cnt == 8) begin
                m_cnt = 0;
                if (!m_loading) begin
                    exp_val.push_back(dot());
                    exp_cyc.push_back(cyc + 4);
                end
                m_loading = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, $urandom, 1'b0);
    endtask

    task automatic frame(input int k0);
        for (int k = k0; k < k0 + 8; k++) drive(1'b1, {16'(k), 16'(k)}, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom));
            vecs++;
            if (dout_v !== 1'b0 || dout !== 32'h0) begin
                errs++;
                $display("FAIL reset cycle %0d: dout_v=%b dout=%h, want 0/00000000", i, dout_v, dout);
            end
        end
        rst = 1'b1;
        obs_val.delete(); obs_cyc.delete();
    endtask

    task automatic test_first_frame();
        logic [31:0] c [8];
        int last;
        c = '{32'h0004_0002, 32'h0003_0001, 32'h0008_0006, 32'h0007_0005,
              32'h000c_000a, 32'h000b_0009, 32'h0004_0002, 32'h0003_0001};
        for (int i = 0; i < 8; i++) drive(1'b1, c[i], 1'b0);
        vecs++;
        if (obs_val.size() != 0) begin errs++; $display("FAIL coef_no_output: got %0d outputs, want 0", obs_val.size()); end
        frame(1);
        last = cyc;
        idle(8);
        vecs++;
        if (obs_val.size() != 1 || obs_val[0] !== 32'h0048_0198 || obs_cyc[0] != last + 4) begin
            errs++;
            $display("FAIL first_frame: got %0d outputs first=%h at +%0d, want 1 output 00480198 at +4",
                     obs_val.size(), obs_val.size() ? obs_val[0] : 32'h0, obs_val.size() ? obs_cyc[0] - last : -1);
        end
        obs_val.delete(); obs_cyc.delete(); exp_val.delete(); exp_cyc.delete();
    endtask

    task automatic test_back_to_back();
        frame(9);
        frame(1);
        for (int i = 0; i < 12; i++) drive(1'b0, $urandom, 1'b0);
        vecs++;
        if (obs_val.size() != 2) begin
            errs++; $display("FAIL b2b_count: got %0d outputs, want 2", obs_val.size());
        end else begin
            vecs++;
            if (obs_val[0] !== 32'h00C8_0458 || obs_val[1] !== 32'h0048_0198) begin
                errs++; $display("FAIL b2b_values: got %h %h, want 00c80458 00480198", obs_val[0], obs_val[1]);
            end
            vecs++;
            if (obs_cyc[1] - obs_cyc[0] != 8) begin
                errs++; $display("FAIL b2b_spacing: got %0d, want 8", obs_cyc[1] - obs_cyc[0]);
            end
            vecs++;
            if (obs_cyc[0] != exp_cyc[0] || obs_cyc[1] != exp_cyc[1]) begin
                errs++; $display("FAIL b2b_timing: got %0d %0d, want %0d %0d", obs_cyc[0], obs_cyc[1], exp_cyc[0], exp_cyc[1]);
            end
        end
        obs_val.delete(); obs_cyc.delete(); exp_val.delete(); exp_cyc.delete();
    endtask

    task automatic test_gaps();
        int last;
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, {16'(k), 16'(k)}, 1'b0);
            if (k == 4) idle(3);
        end
        last = cyc;
        idle(8);
        vecs++;
        if (obs_val.size() != 1 || obs_val[0] !== 32'h0048_0198 || obs_cyc[0] != last + 4) begin
            errs++;
            $display("FAIL gaps: got %0d outputs first=%h at +%0d, want 1 output 00480198 at +4",
                     obs_val.size(), obs_val.size() ? obs_val[0] : 32'h0, obs_val.size() ? obs_cyc[0] - last : -1);
        end
        obs_val.delete(); obs_cyc.delete(); exp_val.delete(); exp_cyc.delete();
    endtask

    task automatic test_reload();
        for (int k = 1; k <= 5; k++) drive(1'b1, {16'(k), 16'(k)}, 1'b0);
        drive(1'b1, 32'h0006_0006, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b1, 32'h0001_0000, 1'b0);
        vecs++;
        if (obs_val.size() != 0 || dout !== 32'h0048_0198) begin
            errs++; $display("FAIL reload_abort: got %0d outputs dout=%h, want 0 outputs dout held 00480198", obs_val.size(), dout);
        end
        frame(1);
        idle(8);
        vecs++;
        if (obs_val.size() != 1 || obs_val[0] !== 32'h0024_0024) begin
            errs++; $display("FAIL reload_result: got %0d outputs first=%h, want 1 output 00240024",
                             obs_val.size(), obs_val.size() ? obs_val[0] : 32'h0);
        end
        obs_val.delete(); obs_cyc.delete(); exp_val.delete(); exp_cyc.delete();
    endtask

    task automatic test_wrap();
        drive(1'b0, $urandom, 1'b1);
        for (int i = 0; i < 16; i++) drive(1'b1, 32'h7fff_0000, 1'b0);
        idle(8);
        vecs++;
        if (obs_val.size() != 1 || obs_val[0] !== 32'h0008_0000) begin
            errs++; $display("FAIL wrap: got %0d outputs first=%h, want 1 output 00080000",
                             obs_val.size(), obs_val.size() ? obs_val[0] : 32'h0);
        end
        obs_val.delete(); obs_cyc.delete(); exp_val.delete(); exp_cyc.delete();
    endtask

    task automatic test_random();
        int r, n;
        drive(1'b1, $urandom, 1'b1);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 59);
            if (r == 0)      drive(1'($urandom), $urandom, 1'b1);
            else if (r < 12) drive(1'b0, $urandom, 1'b0);
            else             drive(1'b1, $urandom, 1'b0);
        end
        idle(10);
        vecs++;
        if (obs_val.size() != exp_val.size()) begin
            errs++; $display("FAIL random_count: got %0d outputs, want %0d", obs_val.size(), exp_val.size());
        end
        n = (obs_val.size() < exp_val.size()) ? obs_val.size() : exp_val.size();
        for (int i = 0; i < n; i++) begin
            vecs++;
            if (obs_val[i] !== exp_val[i] || obs_cyc[i] != exp_cyc[i]) begin
                errs++; $display("FAIL random_out[%0d]: got %h at %0d, want %h at %0d",
                                 i, obs_val[i], obs_cyc[i], exp_val[i], exp_cyc[i]);
            end
        end
        obs_val.delete(); obs_cyc.delete(); exp_val.delete(); exp_cyc.delete();
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_gaps();
        test_reload();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
